// File: rtl/vga_timing_detector.sv
// Receive-side VGA/HDMI timing detector: recovers pixel coordinates from
// hsync/vsync/vde, measures line and frame timing, and flags stable timing.
module vga_timing_detector #(
  parameter int unsigned CW          = 12,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          vde,
  output logic          de_o,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          frame_start,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] h_sync_w,
  output logic [CW-1:0] h_active,
  output logic [CW-1:0] v_total,
  output logic [CW-1:0] v_sync_w,
  output logic          locked
);

  localparam logic [CW-1:0] MAX    = {CW{1'b1}};
  localparam logic [CW-1:0] ONE    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] LOCK_N = CW'(LOCK_FRAMES);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == MAX) ? v : v + ONE;
  endfunction

  // Two-stage input pipeline
  logic hs1, hs2, vs1, vs2, de1, de2;
  // Running counters
  logic [CW-1:0] hcnt, hsw_cnt, hact_cnt, lcnt, vsw_cnt, match_cnt;
  logic          pending, prev_valid;
  logic [4*CW-1:0] prev_snap;

  logic hs_rise, hs_fall, vs_rise, vs_fall, de_rise, de_fall;
  logic [CW-1:0] h_total_d, h_sync_w_d, h_active_d, v_total_d, v_sync_w_d, match_cnt_d;
  logic [4*CW-1:0] snap;
  logic locked_d;

  // Edge detection, measurement latches and lock decision
  always_comb begin
    hs_rise = hs1 & ~hs2;
    hs_fall = ~hs1 & hs2;
    vs_rise = vs1 & ~vs2;
    vs_fall = ~vs1 & vs2;
    de_rise = de1 & ~de2;
    de_fall = ~de1 & de2;

    h_total_d  = hs_rise ? sat_inc(hcnt) : h_total;
    h_sync_w_d = hs_fall ? hsw_cnt       : h_sync_w;
    h_active_d = de_fall ? hact_cnt      : h_active;
    v_total_d  = vs_rise ? sat_inc(lcnt) : v_total;
    v_sync_w_d = vs_fall ? vsw_cnt       : v_sync_w;

    // Snapshot sees latches made in this same cycle
    snap = {h_total_d, h_sync_w_d, v_total_d, v_sync_w_d};

    match_cnt_d = match_cnt;
    if (vs_rise) begin
      match_cnt_d = (prev_valid && (snap == prev_snap)) ? sat_inc(match_cnt) : '0;
    end
    locked_d = (match_cnt_d >= LOCK_N);
    // Saturated hcnt means hsync has vanished: drop lock straight away
    if (hcnt == MAX) begin
      match_cnt_d = '0;
      locked_d    = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      {hs1, hs2, vs1, vs2, de1, de2} <= '0;
      hcnt        <= '0;
      hsw_cnt     <= '0;
      hact_cnt    <= '0;
      lcnt        <= '0;
      vsw_cnt     <= '0;
      match_cnt   <= '0;
      pending     <= 1'b0;
      prev_valid  <= 1'b0;
      prev_snap   <= '0;
      de_o        <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      h_total     <= '0;
      h_sync_w    <= '0;
      h_active    <= '0;
      v_total     <= '0;
      v_sync_w    <= '0;
      locked      <= 1'b0;
    end else begin
      hs1 <= hsync;
      hs2 <= hs1;
      vs1 <= vsync;
      vs2 <= vs1;
      de1 <= vde;
      de2 <= de1;

      hcnt <= hs_rise ? '0 : sat_inc(hcnt);

      if (hs_rise)  hsw_cnt <= ONE;
      else if (hs1) hsw_cnt <= sat_inc(hsw_cnt);

      if (de_rise)  hact_cnt <= ONE;
      else if (de1) hact_cnt <= sat_inc(hact_cnt);

      // Clear beats the increment when vsync and hsync rise together
      if (vs_rise)      lcnt <= '0;
      else if (hs_rise) lcnt <= sat_inc(lcnt);

      if (vs_rise)             vsw_cnt <= ONE;
      else if (hs_rise && vs1) vsw_cnt <= sat_inc(vsw_cnt);

      if (de_rise)  pix_x <= '0;
      else if (de1) pix_x <= sat_inc(pix_x);

      if (de_rise) begin
        if (pending || vs_rise) pix_y <= '0;
        else                    pix_y <= sat_inc(pix_y);
        pending <= 1'b0;
      end else if (vs_rise) begin
        pending <= 1'b1;
      end

      if (vs_rise) begin
        prev_snap  <= snap;
        prev_valid <= 1'b1;
      end

      de_o        <= de1;
      frame_start <= vs_rise;
      h_total     <= h_total_d;
      h_sync_w    <= h_sync_w_d;
      h_active    <= h_active_d;
      v_total     <= v_total_d;
      v_sync_w    <= v_sync_w_d;
      match_cnt   <= match_cnt_d;
      locked      <= locked_d;
    end
  end

endmodule
